multiplier_pipelined: RTL and testbench

MULTIPLIER_PIPELINED -- requirements
Module: multiplier_pipelined

---
 rtl/multiplier_pipelined_pkg.sv | 21 ++
 rtl/multiplier_pipelined_mul_half.sv | 35 +++
 rtl/multiplier_pipelined.sv | 142 ++++++++++++++
 tb/tb_multiplier_pipelined.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/multiplier_pipelined_pkg.sv
// -----------------------------------------------------------------------------
// multiplier_pipelined_pkg
//
// Purpose:
//    Shared width constants for the pipelined unsigned multiplier. The
//    default operand width is 32 bits. The half width (one operand slice)
//    and the full product width are derived from it so the sub-module and
//    the top level agree on their default sizes.
//
// Contents:
//    MP_WIDTH       default operand width in bits
//    MP_HALF_WIDTH  width of one operand half
//    MP_PROD_WIDTH  width of the full-precision product
// -----------------------------------------------------------------------------
package multiplier_pipelined_pkg;

    localparam int MP_WIDTH      = 32;
    localparam int MP_HALF_WIDTH = MP_WIDTH / 2;
    localparam int MP_PROD_WIDTH = 2 * MP_WIDTH;

endpackage : multiplier_pipelined_pkg

// File: rtl/multiplier_pipelined_mul_half.sv
// -----------------------------------------------------------------------------
// mul_half
//
// Purpose:
//    Purely combinational unsigned multiply of two half-width slices. The
//    top level uses four of these to form the partial products of a
//    split-operand multiply. No state is held here; the caller registers
//    the result.
//
// Parameters:
//    HW    slice width in bits
//
// Ports:
//    x_i   input  [HW-1:0]    first unsigned slice
//    y_i   input  [HW-1:0]    second unsigned slice
//    p_o   output [2*HW-1:0]  full-precision unsigned product x_i * y_i
// -----------------------------------------------------------------------------
module mul_half
    import multiplier_pipelined_pkg::*;
#(
    parameter int HW = MP_HALF_WIDTH
) (
    input  logic [HW-1:0]   x_i,
    input  logic [HW-1:0]   y_i,
    output logic [2*HW-1:0] p_o
);

    // Both operands are zero-extended to the product width before the
    // multiply so the result is computed at full precision and stays
    // unsigned regardless of how the tools size the expression.
    always_comb begin
        p_o = {{HW{1'b0}}, x_i} * {{HW{1'b0}}, y_i};
    end

endmodule : mul_half

// File: rtl/multiplier_pipelined.sv
// -----------------------------------------------------------------------------
// multiplier_pipelined
//
// Purpose:
//    Two-stage pipelined unsigned multiplier. A new operand pair is accepted
//    on every rising clock edge and its full-precision product appears on r
//    just after the following edge.
//
//    Stage 1 splits both operands into high and low halves and registers the
//    four half-by-half partial products. Stage 2 recombines them as
//       r = PP_HH << WIDTH + (PP_HL + PP_LH) << WIDTH/2 + PP_LL
//    and registers the result, so r is always driven straight from a flop.
//
// Parameters:
//    WIDTH  operand width in bits, any even value of 4 or more
//
// Ports:
//    clk    input                 rising-edge clock
//    rst    input                 asynchronous active-high reset, clears
//                                 every pipeline register
//    a      input  [WIDTH-1:0]    unsigned multiplicand
//    b      input  [WIDTH-1:0]    unsigned multiplier
//    r      output [2*WIDTH-1:0]  registered unsigned product
// -----------------------------------------------------------------------------
module multiplier_pipelined
    import multiplier_pipelined_pkg::*;
#(
    parameter int WIDTH = MP_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] r
);

    localparam int HALF = WIDTH / 2;
    localparam int PROD = 2 * WIDTH;

    // Operand halves
    logic [HALF-1:0]  aLo;
    logic [HALF-1:0]  aHi;
    logic [HALF-1:0]  bLo;
    logic [HALF-1:0]  bHi;

    // Stage-1 partial products: next-state from the multipliers, and the
    // registered copies that feed stage 2
    logic [WIDTH-1:0] ppLl_d;
    logic [WIDTH-1:0] ppLh_d;
    logic [WIDTH-1:0] ppHl_d;
    logic [WIDTH-1:0] ppHh_d;
    logic [WIDTH-1:0] ppLl_q;
    logic [WIDTH-1:0] ppLh_q;
    logic [WIDTH-1:0] ppHl_q;
    logic [WIDTH-1:0] ppHh_q;

    // Stage-2 recombination and output register
    logic [WIDTH:0]   midSum;
    logic [PROD-1:0]  prod_d;
    logic [PROD-1:0]  prod_q;

    // Split each operand into its low and high halves. Naming follows the
    // partial-product convention: the first letter is the a half, the second
    // letter is the b half.
    always_comb begin
        aLo = a[HALF-1:0];
        aHi = a[WIDTH-1:HALF];
        bLo = b[HALF-1:0];
        bHi = b[WIDTH-1:HALF];
    end

    // Four half-width multipliers generate the partial products. They are
    // purely combinational; the registers that hold their results live in
    // this module so the pipeline boundary is visible in one place.
    mul_half #(.HW(HALF)) uMulLl (
        .x_i (aLo),
        .y_i (bLo),
        .p_o (ppLl_d)
    );

    mul_half #(.HW(HALF)) uMulLh (
        .x_i (aLo),
        .y_i (bHi),
        .p_o (ppLh_d)
    );

    mul_half #(.HW(HALF)) uMulHl (
        .x_i (aHi),
        .y_i (bLo),
        .p_o (ppHl_d)
    );

    mul_half #(.HW(HALF)) uMulHh (
        .x_i (aHi),
        .y_i (bHi),
        .p_o (ppHh_d)
    );

    // Stage 1 register: capture all four partial products on the edge that
    // samples the operands. Operand activity between edges therefore never
    // reaches the output. Reset clears the stage immediately so any product
    // in flight is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ppLl_q <= '0;
            ppLh_q <= '0;
            ppHl_q <= '0;
            ppHh_q <= '0;
        end else begin
            ppLl_q <= ppLl_d;
            ppLh_q <= ppLh_d;
            ppHl_q <= ppHl_d;
            ppHh_q <= ppHh_d;
        end
    end

    // Stage 2 combine. The two cross terms can together exceed WIDTH bits,
    // so they are summed at WIDTH+1 bits to keep that carry. PP_HH and PP_LL
    // occupy disjoint bit ranges of the product, so they are simply
    // concatenated; only the shifted middle term needs a real addition.
    // The middle term is zero-padded on top to the full product width.
    always_comb begin
        midSum = {1'b0, ppHl_q} + {1'b0, ppLh_q};
        prod_d = {ppHh_q, ppLl_q}
               + {{(HALF - 1){1'b0}}, midSum, {HALF{1'b0}}};
    end

    // Stage 2 register: the output is taken directly from this flop so
    // there is no combinational path from the operands to r. Reset clears
    // it together with stage 1, so r reads zero until the first product
    // captured after reset has passed through both stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
        end
    end

    assign r = prod_q;

endmodule : multiplier_pipelined

// File: tb/tb_multiplier_pipelined.sv
// -----------------------------------------------------------------------------
// tb_multiplier_pipelined
//
// Self-checking bench for the 32-bit pipelined multiplier. A reference model
// keeps a queue of products captured on each clock edge and reports the one
// the output should currently be showing. Fixed vectors come from a table of
// hand-computed products; the remaining sequences cover holding operands,
// a long incrementing stream, a mid-stream reset and random operands.
// -----------------------------------------------------------------------------
module tb_multiplier_pipelined;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] expR;
        string          name;
    } vec_t;

    logic           clk;
    logic           rst;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] r;

    int checks   = 0;
    int failures = 0;

    // Reference model state: products captured on each edge, oldest first,
    // and the value r is expected to show right now.
    logic [2*W-1:0] captured[$];
    logic [2*W-1:0] modelR = '0;

    multiplier_pipelined #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .r   (r)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: each edge captures a*b; a product becomes
    // visible once the next edge has been taken. Reset forgets everything
    // and forces the expected output to zero straight away.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            captured.delete();
            modelR = '0;
        end else begin
            captured.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
            if (captured.size() > 1) begin
                modelR = captured.pop_front();
            end else begin
                modelR = '0;
            end
        end
    end

    // Compare r against an expected value and count the result
    task automatic checkOutput(input string name, input logic [2*W-1:0] expVal);
        checks++;
        if (r !== expVal) begin
            failures++;
            $display("[TB] FAIL %s: r=%h expected=%h at t=%0t", name, r, expVal, $time);
        end
    endtask

    // Drive the next operand pair. Between edges the operands are first
    // scrambled and r is checked for stability, then the real values are
    // applied 1 ns before the upcoming rising edge.
    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        a = $urandom;
        b = $urandom;
        #1;
        checkOutput("stable_between_edges", modelR);
        #3;
        a = av;
        b = bv;
    endtask

    // Advance to 1 ns past the next rising edge
    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tab[10];
        logic [W-1:0] va;
        logic [W-1:0] vb;

        tab[0] = '{32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000, "zero_times_x"};
        tab[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "all_ones_sq"};
        tab[2] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, "half_carry"};
        tab[3] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, "no_sign_ext"};
        tab[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 64'h0000_0000_0000_0000, "x_times_zero"};
        tab[5] = '{32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, "low_halves"};
        tab[6] = '{32'hFFFF_0000, 32'hFFFF_0000, 64'hFFFE_0001_0000_0000, "high_halves"};
        tab[7] = '{32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, "times_one"};
        tab[8] = '{32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, "shift_by_16"};
        tab[9] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, "three_five"};

        rst = 1'b1;
        a   = '0;
        b   = '0;

        // Reset state
        #2;
        checkOutput("reset_r", 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors back to back: each product shows one edge after
        // the edge that captured it, so check the previous entry.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(tab[i].a, tab[i].b);
            waitEdge();
            if (i == 0) begin
                checkOutput("first_after_reset", 64'h0);
            end else begin
                checkOutput(tab[i-1].name, tab[i-1].expR);
            end
        end
        applyStimulus(32'h0, 32'h0);
        waitEdge();
        checkOutput(tab[9].name, tab[9].expR);

        // Hold 3 x 5 for four edges; the previous capture was 0 x 0
        for (int k = 0; k < 4; k++) begin
            applyStimulus(32'd3, 32'd5);
            waitEdge();
            checkOutput("hold_3x5", (k == 0) ? 64'h0 : 64'd15);
        end

        // Long incrementing stream against the reference model
        va = '0;
        vb = '0;
        for (int n = 0; n < 10000; n++) begin
            applyStimulus(va, vb);
            waitEdge();
            checkOutput("stream", modelR);
            va = va + 32'h2345_6789;
            vb = vb + 32'h3456_7891;
        end

        // Mid-stream reset held for half a cycle between edges
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_immediate", 64'h0);
        #4;
        rst = 1'b0;
        #2;
        a = 32'h0000_1234;
        b = 32'h0000_0100;
        waitEdge();
        checkOutput("rst_next_edge", 64'h0);
        applyStimulus(32'hDEAD_BEEF, 32'h0000_0001);
        waitEdge();
        checkOutput("post_rst_product", 64'h0000_0000_0012_3400);
        applyStimulus(32'h0, 32'h0);
        waitEdge();
        checkOutput("post_rst_second", 64'h0000_0000_DEAD_BEEF);

        // Random operands against the reference model
        for (int n = 0; n < 300; n++) begin
            applyStimulus($urandom, $urandom);
            waitEdge();
            checkOutput("random", modelR);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_multiplier_pipelined
